// File: rtl/au_sequencer.sv
// Sequencing controller for the 8-bit add/subtract AU: debounces ENTER/CLEAR and
// steps through A load, B load, operation confirm and a settle-timed result capture.
module au_sequencer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SETTLE_CYCLES   = 4
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       KEY_ENTER,
  input  logic       KEY_CLEAR,
  input  logic       SW_SUB,
  input  logic       OVR,
  input  logic       Cout,
  output logic       LoadA,
  output logic       LoadB,
  output logic       LoadR,
  output logic       ADDSUB,
  output logic       au_clr,
  output logic [1:0] phase,
  output logic       busy,
  output logic       OVR_flag,
  output logic       Cout_flag
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] CNT_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] CNT_ONE = DW'(1);
  localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES);

  logic [1:0] key_raw;
  logic [1:0] key_evt;

  assign key_raw = {KEY_CLEAR, KEY_ENTER};

  // Index 0 = ENTER, index 1 = CLEAR; both keys get identical conditioning.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_key
      logic          sync1_q, sync2_q;
      logic          db_q, db_d;
      logic          evt_q, evt_d;
      logic [DW-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        evt_d = 1'b0;
        if (sync2_q != db_q) begin
          if (cnt_q == CNT_MAX) begin
            db_d  = sync2_q;
            evt_d = ~sync2_q;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
          sync1_q <= 1'b1;
          sync2_q <= 1'b1;
          db_q    <= 1'b1;
          evt_q   <= 1'b0;
          cnt_q   <= '0;
        end else begin
          sync1_q <= key_raw[gi];
          sync2_q <= sync1_q;
          db_q    <= db_d;
          evt_q   <= evt_d;
          cnt_q   <= cnt_d;
        end
      end

      assign key_evt[gi] = evt_q;
    end
  endgenerate

  typedef enum logic [2:0] {S_A, S_B, S_OP, S_SETTLE, S_RES} state_t;

  state_t     state_q, state_d;
  logic [7:0] settle_q, settle_d;
  logic       load_a_q, load_a_d;
  logic       load_b_q, load_b_d;
  logic       load_r_q, load_r_d;
  logic       clr_q, clr_d;
  logic       addsub_q, addsub_d;
  logic       ovr_flag_q, ovr_flag_d;
  logic       cout_flag_q, cout_flag_d;
  logic [1:0] phase_q, phase_d;
  logic       busy_q, busy_d;
  logic       enter_evt, clear_evt;

  assign enter_evt = key_evt[0];
  assign clear_evt = key_evt[1];

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    load_a_d    = 1'b0;
    load_b_d    = 1'b0;
    load_r_d    = 1'b0;
    clr_d       = 1'b0;
    addsub_d    = addsub_q;
    ovr_flag_d  = ovr_flag_q;
    cout_flag_d = cout_flag_q;

    // Clear overrides everything, including a simultaneous enter.
    if (clear_evt) begin
      state_d     = S_A;
      settle_d    = '0;
      clr_d       = 1'b1;
      addsub_d    = 1'b0;
      ovr_flag_d  = 1'b0;
      cout_flag_d = 1'b0;
    end else begin
      case (state_q)
        S_A: if (enter_evt) begin
          load_a_d = 1'b1;
          state_d  = S_B;
        end
        S_B: if (enter_evt) begin
          load_b_d = 1'b1;
          state_d  = S_OP;
        end
        S_OP: if (enter_evt) begin
          addsub_d = SW_SUB;
          settle_d = SETTLE_INIT;
          state_d  = S_SETTLE;
        end
        S_SETTLE: begin
          // LoadR is issued as the count lands on 0; state leaves one cycle later
          // so busy covers the strobe cycle.
          if (settle_q == 8'd0) begin
            state_d = S_RES;
          end else begin
            settle_d = settle_q - 8'd1;
            if (settle_q == 8'd1) begin
              load_r_d    = 1'b1;
              ovr_flag_d  = OVR;
              cout_flag_d = Cout;
            end
          end
        end
        S_RES: if (enter_evt) begin
          state_d = S_A;
        end
        default: state_d = S_A;
      endcase
    end

    case (state_d)
      S_A:     phase_d = 2'd0;
      S_B:     phase_d = 2'd1;
      S_OP:    phase_d = 2'd2;
      default: phase_d = 2'd3;
    endcase
    busy_d = (state_d == S_SETTLE);
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q     <= S_A;
      settle_q    <= '0;
      load_a_q    <= 1'b0;
      load_b_q    <= 1'b0;
      load_r_q    <= 1'b0;
      clr_q       <= 1'b0;
      addsub_q    <= 1'b0;
      ovr_flag_q  <= 1'b0;
      cout_flag_q <= 1'b0;
      phase_q     <= 2'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      load_a_q    <= load_a_d;
      load_b_q    <= load_b_d;
      load_r_q    <= load_r_d;
      clr_q       <= clr_d;
      addsub_q    <= addsub_d;
      ovr_flag_q  <= ovr_flag_d;
      cout_flag_q <= cout_flag_d;
      phase_q     <= phase_d;
      busy_q      <= busy_d;
    end
  end

  assign LoadA     = load_a_q;
  assign LoadB     = load_b_q;
  assign LoadR     = load_r_q;
  assign au_clr    = clr_q;
  assign ADDSUB    = addsub_q;
  assign OVR_flag  = ovr_flag_q;
  assign Cout_flag = cout_flag_q;
  assign phase     = phase_q;
  assign busy      = busy_q;

endmodule

// File: doc/au_sequencer.md
# au_sequencer

Sequencing controller for the 8-bit add/subtract arithmetic unit. It turns two raw pushbuttons and an operation switch into the AU's operand-load, result-load, operation-select and clear controls. Each press of ENTER advances a fixed flow: load A, load B, confirm the operation, then a settle-timed result capture with latched flags. It sits between the board I/O and the AU, and owns every AU control input.

## Interface

Parameters:
- DEBOUNCE_CYCLES, default 250000: consecutive stable cycles required before a button level is accepted. Legal range 2 or more.
- SETTLE_CYCLES, default 4: cycles between operation confirm and the result strobe. Legal range 1–255.

Ports:
- CLK  in  1  system clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low reset; one clock, one reset domain.
- KEY_ENTER  in  1  raw pushbutton, active-low (0 = pressed), asynchronous to CLK.
- KEY_CLEAR  in  1  raw pushbutton, active-low, asynchronous to CLK.
- SW_SUB  in  1  operation switch: 1 = subtract, 0 = add.
- OVR  in  1  AU signed-overflow output.
- Cout  in  1  AU carry-out.
- LoadA  out  1  one-cycle high strobe. The AU captures BIT_Input into A on the strobe's falling edge.
- LoadB  out  1  same as LoadA, for operand B.
- LoadR  out  1  same as LoadA, for the result register.
- ADDSUB  out  1  AU operation select (1 = subtract), registered.
- au_clr  out  1  one-cycle high pulse that clears the AU registers.
- phase  out  2  current step: 0 = A entry, 1 = B entry, 2 = operation entry, 3 = result shown or settling.
- busy  out  1  high while in S_SETTLE.
- OVR_flag  out  1  OVR value latched at result capture.
- Cout_flag  out  1  Cout value latched at result capture.

## Operation

Button conditioning (identical for each key):
- Each key passes through a 2-FF synchronizer.
- The debounced level updates when the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any agreeing cycle restarts the count.
- A press event is a one-cycle internal pulse on a debounced 1→0 transition. Releases generate no event.
- Holding a key produces exactly one event.

FSM states and transitions (enter = ENTER event, clear = CLEAR event):
- S_A (phase 0): on enter, pulse LoadA and go to S_B.
- S_B (phase 1): on enter, pulse LoadB and go to S_OP.
- S_OP (phase 2): on enter, register ADDSUB ← SW_SUB, load the settle counter with SETTLE_CYCLES, and go to S_SETTLE.
- S_SETTLE (phase 3, busy = 1): decrement the counter each cycle. When it reaches 0, pulse LoadR, latch OVR_flag ← OVR and Cout_flag ← Cout, and go to S_RES.
- S_RES (phase 3): on enter, go to S_A. Result and flags are held; no strobe is issued.
- Enter events in S_SETTLE are dropped, not queued.

Clear handling:
- Clear in any state: go to S_A, pulse au_clr, set ADDSUB, OVR_flag and Cout_flag to 0, and abort any settle count.
- Clear and enter in the same cycle: clear wins and the enter is discarded.

Signal rules:
- ADDSUB changes only at S_OP confirm or on clear/reset. It is stable from confirm through the LoadR strobe and afterwards.
- SW_SUB is ignored outside the S_OP confirm cycle.
- At most one of LoadA, LoadB, LoadR, au_clr is high in any cycle.

Reset:
- Reset asserted at any time, including mid-settle, takes effect immediately.
- Reset values: state S_A, all strobes 0, au_clr 0, ADDSUB 0, phase 0, busy 0, both flags 0, debounced levels released (1), all counters 0.

## Timing

- All outputs are registered, so there are no combinational paths from inputs to outputs.
- Strobe latency: a strobe is high for exactly 1 cycle, in the cycle after the press event. The event itself occurs 2 + DEBOUNCE_CYCLES cycles after a clean raw edge.
- phase changes in the same cycle the strobe rises.
- LoadR rises SETTLE_CYCLES + 1 cycles after the S_OP enter event. Flags update in the same cycle LoadR rises.
- busy is high from the cycle after the confirm event through the cycle LoadR rises, then drops.
- Back-to-back events are accepted one per cycle in non-settle states. The minimum separation between presses is set by debounce only.

## Test plan

All scenarios use DEBOUNCE_CYCLES = 4 and SETTLE_CYCLES = 2.

- **Reset values:** assert reset mid-run → all outputs at their reset values within the same cycle; phase = 0.
- **Full add flow:** SW_SUB = 0, four clean ENTER presses → LoadA, LoadB, then LoadR each 1 cycle wide. LoadR occurs 3 cycles after the third event. ADDSUB = 0 and phase goes 0→1→2→3→3. The fourth press returns phase to 0.
- **Subtract with overflow:** SW_SUB = 1, model drives OVR = 1, Cout = 0 → ADDSUB = 1 before LoadR, OVR_flag = 1, Cout_flag = 0. Toggling SW_SUB in S_RES leaves ADDSUB at 1.
- **Bounce rejection:** ENTER toggles every 2 cycles for 20 cycles, then holds low → exactly one LoadA, issued 2 + 4 + 1 cycles after the hold begins. Holding for 100 cycles gives no further strobes.
- **Enter during settle:** ENTER event during S_SETTLE → dropped, no extra strobe, LoadR at the nominal cycle. Enter and clear events in the same cycle in S_B → au_clr pulses, phase = 0, no LoadB.
- **Clear mid-settle:** CLEAR event while busy = 1 → no LoadR, busy drops, au_clr pulses once, ADDSUB = 0, flags = 0, and the next ENTER issues LoadA.
